// File: rtl/seg7_pkg.sv
// Seven-segment helpers shared by the score/high-score tracker.
// Contents: active-low digit codes SEG_0..SEG_9, blank code, seg7_encode(),
//           FSM state type and the MSD-first compare decision type.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   // Decision so far while scanning from the most significant digit down
   typedef enum logic [1:0] {DEC_NONE, DEC_GT, DEC_LT} dec_t;

   // BCD digit to active-low segments; anything above 9 shows blank
   function automatic logic [6:0] seg7_encode(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/score_hex_tracker_if.sv
// Bus between the game logic and the score/high-score tracker.
// master: start, clear_hi, score_hex out; results and high score in.
// slave : the tracker side of the same signals.
interface score_hex_tracker_if #(
   parameter int unsigned NDIGITS = 2
) ();
   logic                      start;
   logic                      clear_hi;
   logic [NDIGITS-1:0][6:0]   score_hex;
   logic                      busy;
   logic                      done;
   logic                      gt;
   logic                      eq;
   logic                      lt;
   logic                      err;
   logic [NDIGITS-1:0][3:0]   hi_bcd;
   logic [NDIGITS-1:0][6:0]   hi_hex;

   modport master (
      output start, clear_hi, score_hex,
      input  busy, done, gt, eq, lt, err, hi_bcd, hi_hex
   );

   modport slave (
      input  start, clear_hi, score_hex,
      output busy, done, gt, eq, lt, err, hi_bcd, hi_hex
   );
endinterface

// File: rtl/seg7_decode.sv
// Strict active-low seven-segment decoder.
// code    : 7-bit active-low segment pattern
// value_c : decoded digit 0-9 (4'hF when illegal)
// valid_c : 1 only for the ten legal digit patterns
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] code,
   output logic [3:0] value_c,
   output logic       valid_c
);

   // Illegal patterns report invalid and never decode as 0
   always_comb begin
      value_c = 4'hF;
      valid_c = 1'b0;
      case (code)
         SEG_0: begin value_c = 4'd0; valid_c = 1'b1; end
         SEG_1: begin value_c = 4'd1; valid_c = 1'b1; end
         SEG_2: begin value_c = 4'd2; valid_c = 1'b1; end
         SEG_3: begin value_c = 4'd3; valid_c = 1'b1; end
         SEG_4: begin value_c = 4'd4; valid_c = 1'b1; end
         SEG_5: begin value_c = 4'd5; valid_c = 1'b1; end
         SEG_6: begin value_c = 4'd6; valid_c = 1'b1; end
         SEG_7: begin value_c = 4'd7; valid_c = 1'b1; end
         SEG_8: begin value_c = 4'd8; valid_c = 1'b1; end
         SEG_9: begin value_c = 4'd9; valid_c = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/score_hex_tracker.sv
// Captures a seven-segment score, compares it digit-serially (MSD first)
// against the stored high score and optionally replaces the high score.
// clk, reset : clock, asynchronous active-high reset
// bus.start / bus.clear_hi / bus.score_hex : requests and score, sampled in IDLE
// bus.busy / bus.done / bus.gt / bus.eq / bus.lt / bus.err : status and result
// bus.hi_bcd / bus.hi_hex : stored high score, BCD and active-low segments
module score_hex_tracker
   import seg7_pkg::*;
#(
   parameter int unsigned NDIGITS     = 2,
   parameter bit          AUTO_UPDATE = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   score_hex_tracker_if.slave bus
);

   localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   state_t                    state_q, state_d;
   logic [NDIGITS-1:0][6:0]   shadow_q, shadow_d;
   logic [IW-1:0]             idx_q, idx_d;
   dec_t                      dec_q, dec_d;
   logic                      bad_q, bad_d;
   logic [NDIGITS-1:0][3:0]   bcd_q, bcd_d;
   logic [NDIGITS-1:0][3:0]   hi_q, hi_d;
   logic                      gt_q, gt_d;
   logic                      eq_q, eq_d;
   logic                      lt_q, lt_d;
   logic                      err_q, err_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   logic [6:0]                cur_code_c;
   logic [3:0]                cur_val_c;
   logic                      cur_ok_c;
   dec_t                      dec_n;
   logic                      bad_n;

   // Single decoder shared across digits, steered by the scan index
   assign cur_code_c = shadow_q[idx_q];

   seg7_decode u_dec (
      .code    (cur_code_c),
      .value_c (cur_val_c),
      .valid_c (cur_ok_c)
   );

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      idx_d    = idx_q;
      dec_d    = dec_q;
      bad_d    = bad_q;
      bcd_d    = bcd_q;
      hi_d     = hi_q;
      gt_d     = gt_q;
      eq_d     = eq_q;
      lt_d     = lt_q;
      err_d    = err_q;
      dec_n    = dec_q;
      bad_n    = bad_q;

      case (state_q)
         IDLE: begin
            if (bus.clear_hi) begin
               hi_d = '0;
            end else if (bus.start) begin
               shadow_d = bus.score_hex;
               idx_d    = IW'(NDIGITS - 1);
               dec_d    = DEC_NONE;
               bad_d    = 1'b0;
               gt_d     = 1'b0;
               eq_d     = 1'b0;
               lt_d     = 1'b0;
               err_d    = 1'b0;
               state_d  = SCAN;
            end
         end

         SCAN: begin
            // First differing digit decides; keep scanning so err sees every digit
            if (!cur_ok_c) begin
               bad_n = 1'b1;
            end else if (dec_q == DEC_NONE) begin
               if (cur_val_c > hi_q[idx_q]) begin
                  dec_n = DEC_GT;
               end else if (cur_val_c < hi_q[idx_q]) begin
                  dec_n = DEC_LT;
               end
            end
            dec_d        = dec_n;
            bad_d        = bad_n;
            bcd_d[idx_q] = cur_val_c;

            if (idx_q == '0) begin
               gt_d    = !bad_n && (dec_n == DEC_GT);
               lt_d    = !bad_n && (dec_n == DEC_LT);
               eq_d    = !bad_n && (dec_n == DEC_NONE);
               err_d   = bad_n;
               if (AUTO_UPDATE && gt_d) begin
                  hi_d = bcd_d;
               end
               state_d = DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         idx_q    <= '0;
         dec_q    <= DEC_NONE;
         bad_q    <= 1'b0;
         bcd_q    <= '0;
         hi_q     <= '0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
         dec_q    <= dec_d;
         bad_q    <= bad_d;
         bcd_q    <= bcd_d;
         hi_q     <= hi_d;
         gt_q     <= gt_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.gt     = gt_q;
   assign bus.eq     = eq_q;
   assign bus.lt     = lt_q;
   assign bus.err    = err_q;
   assign bus.hi_bcd = hi_q;

   // High-score display drive, combinational from the stored BCD
   for (genvar g = 0; g < int'(NDIGITS); g++) begin : g_hex
      assign bus.hi_hex[g] = seg7_encode(hi_q[g]);
   end

endmodule

// File: doc/score_hex_tracker.md
# score_hex_tracker

Sequential, parametrised generalisation of the single-digit seven-segment comparator. It captures an NDIGITS-wide score shown on seven-segment displays and decodes each digit with strict validity checking. It compares the score digit-serially, most significant digit first, against a stored high score, and updates that high score when the new score beats it. The block sits between the score counter/HEX drivers and the game-over logic, and drives the high-score HEX displays.

## Interface
- NDIGITS, default 2: number of decimal digits in score and high score (1..8)
- AUTO_UPDATE, default 1: 1 = load the high score when a compare finds score > high score; 0 = never load, compare only
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a compare; accepted only in IDLE
- clear_hi  in  1  zero the high score; accepted only in IDLE
- score_hex  in  [NDIGITS-1:0][6:0]  active-low segment codes; index 0 is the least significant digit
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse when a result is valid
- gt, eq, lt  out  1 each  result flags, held until the next accepted start
- err  out  1  a captured digit was not a legal 0-9 code; held until the next accepted start
- hi_bcd  out  [NDIGITS-1:0][3:0]  stored high score
- hi_hex  out  [NDIGITS-1:0][6:0]  hi_bcd encoded to active-low segments

## Operation
- Legal codes, digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Every other code is illegal. Illegal codes never alias to 0.
- FSM states:
  - IDLE: busy=0.
    - clear_hi=1 zeroes hi_bcd; clear_hi has priority and start is ignored that cycle.
    - Otherwise start=1 captures score_hex into a shadow register, clears gt/eq/lt/err, sets the digit index to NDIGITS-1, and moves to SCAN.
  - SCAN: one digit per cycle, index NDIGITS-1 down to 0.
    - Decode the shadow digit.
    - Illegal code: set the sticky error bit.
    - Otherwise, if no decision has been made yet, compare against hi_bcd[index]. Greater sets the decision to gt; less sets it to lt; equal leaves it undecided.
    - At index 0, move to DONE.
  - DONE: done=1 for exactly this cycle.
    - If the error bit is set: err=1 and gt=eq=lt=0.
    - Otherwise exactly one of gt/eq/lt is 1; eq=1 when no digit differed.
    - If AUTO_UPDATE=1, gt=1 and err=0, hi_bcd loads the decoded shadow digits.
    - Always moves to IDLE next cycle.
- start and clear_hi are ignored outside IDLE.
- score_hex changes after capture do not affect the result.
- Every digit is always scanned, even after a decision, so that err covers the whole score.
- hi_hex is combinational from hi_bcd.

## Timing
- Start accepted at edge k: SCAN occupies cycles k+1 .. k+NDIGITS, and done is high in cycle k+NDIGITS+1. Latency is fixed at NDIGITS+1 cycles, start to done.
- Result flags and hi_bcd update at the edge entering DONE, so they are valid while done=1.
- The earliest next accept is the cycle after DONE. Throughput is one compare per NDIGITS+2 cycles.
- Reset, asynchronous, any state:
  - state goes to IDLE; busy=0, done=0, gt=eq=lt=err=0, hi_bcd=0.
  - hi_hex reads 1000000 on every digit.
  - An in-flight compare is discarded without updating hi_bcd.
- An index counter of $clog2(NDIGITS) bits (minimum 1) wraps nowhere; the SCAN exit is decoded from index==0.

## Structure
- Package seg7_pkg:
  - active-low digit constants SEG_0..SEG_9;
  - function seg7_encode(bcd) -> segments, returning 1111111 (blank) for values >9;
  - typedef of the FSM state enum {IDLE, SCAN, DONE}.
- Sub-module seg7_decode: a combinational 7-bit code -> 4-bit value plus valid flag. One instance is muxed by the digit index.
- Top: FSM, shadow register, digit index counter, decision/error registers, hi_bcd register, and an NDIGITS-wide generate loop of seg7_encode.

## Test plan
- NDIGITS=2, after reset: hi_bcd=00, hi_hex=1000000 x2. Start with score 0100100,1111001 ("21") -> done in cycle 3 after start; gt=1; hi_bcd=21.
- Score "21" again -> eq=1, hi_bcd unchanged. Score "19" -> lt=1 (MSD 1<2 decides; LSD 9>1 is ignored).
- Score with LSD 1111111 (blank) -> err=1, gt=eq=lt=0, hi_bcd unchanged. Illegal MSD with legal LSD -> err=1.
- Pulse start in SCAN and in DONE -> ignored, no extra done. Change score_hex mid-SCAN -> result reflects the captured value.
- clear_hi and start together in IDLE -> hi_bcd=00, no compare. Assert reset during SCAN of a winning score -> hi_bcd keeps its reset value 00, all flags 0.
- AUTO_UPDATE=0, NDIGITS=4: start with "9999" against "0000" -> gt=1 with done at cycle 5; hi_bcd stays 0000.
